// File: rtl/fwnoc_pkg.sv
// Shared NoC package: flit geometry, header length-field placement and the
// arbiter state encoding used by the router egress arbiters.
package fwnoc_pkg;

  localparam int unsigned FWNOC_FLIT_W      = 32;
  localparam int unsigned FWNOC_HDR_LEN_LSB = 16;
  localparam int unsigned FWNOC_HDR_LEN_W   = 8;
  localparam int unsigned FWNOC_NUM_REQ     = 4;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // One-hot encode a 2-bit requester index.
  function automatic logic [FWNOC_NUM_REQ-1:0] fwnoc_onehot4(input logic [1:0] idx);
    logic [FWNOC_NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fwnoc_rr_pkt_arbiter_if.sv
// Bundle of the four ingress request streams, the egress link and the
// arbiter status outputs.
//   master : environment side (drives requests and egress ready)
//   slave  : arbiter side
interface fwnoc_rr_pkt_arbiter_if
  import fwnoc_pkg::*;
#(
  parameter int unsigned DAT_W = FWNOC_FLIT_W
);

  logic [DAT_W-1:0] i0_dat;
  logic [DAT_W-1:0] i1_dat;
  logic [DAT_W-1:0] i2_dat;
  logic [DAT_W-1:0] i3_dat;
  logic             i0_valid;
  logic             i1_valid;
  logic             i2_valid;
  logic             i3_valid;
  logic             i0_ready;
  logic             i1_ready;
  logic             i2_ready;
  logic             i3_ready;

  logic [DAT_W-1:0] e_dat;
  logic             e_valid;
  logic             e_ready;

  logic [3:0]       grant;
  logic             busy;

  modport master (
    output i0_dat, i1_dat, i2_dat, i3_dat,
    output i0_valid, i1_valid, i2_valid, i3_valid,
    input  i0_ready, i1_ready, i2_ready, i3_ready,
    input  e_dat, e_valid,
    output e_ready,
    input  grant, busy
  );

  modport slave (
    input  i0_dat, i1_dat, i2_dat, i3_dat,
    input  i0_valid, i1_valid, i2_valid, i3_valid,
    output i0_ready, i1_ready, i2_ready, i3_ready,
    output e_dat, e_valid,
    input  e_ready,
    output grant, busy
  );

endinterface

// File: rtl/fwnoc_rr_sel4.sv
// Combinational 4-way round-robin priority picker.
//   req     : request vector
//   last    : index of the previous winner; search starts at last+1
//   gnt_idx : index of the first requester found (0 when none)
//   gnt_any : at least one request present
module fwnoc_rr_sel4
  import fwnoc_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       gnt_any
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester after
  // 'last' is the final (winning) assignment. 2-bit adds wrap naturally.
  always_comb begin
    gnt_idx = 2'd0;
    gnt_any = 1'b0;
    cand    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = last + 2'(k) + 2'd1;
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwnoc_rr_pkt_arbiter.sv
// Packet-aware (wormhole) round-robin arbiter for one router egress port.
// Four request streams share one ready/valid egress link. A winning header
// locks the grant until the packet's last flit (1 header + len payload) has
// transferred, so packets never interleave.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   arb   : request streams i0..i3 (dat/valid/ready), egress e_dat/e_valid/
//           e_ready, one-hot grant (0 when idle) and busy status
module fwnoc_rr_pkt_arbiter
  import fwnoc_pkg::*;
#(
  parameter int unsigned DAT_W   = FWNOC_FLIT_W,
  parameter int unsigned LEN_LSB = FWNOC_HDR_LEN_LSB,
  parameter int unsigned LEN_W   = FWNOC_HDR_LEN_W
) (
  input logic                  clock,
  input logic                  reset,
  fwnoc_rr_pkt_arbiter_if.slave arb
);

  localparam logic [LEN_W-1:0] RemOne = LEN_W'(1);

  // Array views of the request streams for indexed muxing.
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [DAT_W-1:0] req_dat [4];

  assign req_valid  = {arb.i3_valid, arb.i2_valid, arb.i1_valid, arb.i0_valid};
  assign req_dat[0] = arb.i0_dat;
  assign req_dat[1] = arb.i1_dat;
  assign req_dat[2] = arb.i2_dat;
  assign req_dat[3] = arb.i3_dat;

  assign arb.i0_ready = req_ready[0];
  assign arb.i1_ready = req_ready[1];
  assign arb.i2_ready = req_ready[2];
  assign arb.i3_ready = req_ready[3];

  arb_state_e       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;   // previous winner; also the current owner while busy
  logic [LEN_W-1:0] rem_q, rem_d;     // payload flits still to come
  logic             hdr_q, hdr_d;     // next transfer of the owner is its header

  logic [1:0]       sel_idx;
  logic             sel_any;

  fwnoc_rr_sel4 u_sel (
    .req     (req_valid),
    .last    (last_q),
    .gnt_idx (sel_idx),
    .gnt_any (sel_any)
  );

  logic [LEN_W-1:0] hdr_len;
  logic [DAT_W-1:0] own_dat;
  logic             own_valid;

  assign own_dat   = req_dat[last_q];
  assign own_valid = req_valid[last_q];
  assign hdr_len   = own_dat[LEN_LSB +: LEN_W];

  logic [DAT_W-1:0] e_dat;
  logic             e_valid;
  logic             xfer;

  // Egress pass-through from the owner while busy; everything quiet when idle.
  always_comb begin
    e_dat     = '0;
    e_valid   = 1'b0;
    req_ready = 4'b0;
    xfer      = 1'b0;
    if (state_q == ARB_BUSY) begin
      e_dat             = own_dat;
      e_valid           = own_valid;
      req_ready[last_q] = arb.e_ready;
      xfer              = own_valid & arb.e_ready;
    end
  end

  assign arb.e_dat   = e_dat;
  assign arb.e_valid = e_valid;
  assign arb.grant   = grant_q;
  assign arb.busy    = (state_q == ARB_BUSY);

  logic pkt_end;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rem_d   = rem_q;
    hdr_d   = hdr_q;
    pkt_end = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (sel_any) begin
          state_d = ARB_BUSY;
          grant_d = fwnoc_onehot4(sel_idx);
          last_d  = sel_idx;
          hdr_d   = 1'b1;
        end
      end
      ARB_BUSY: begin
        // No transfer means every register holds, including the grant.
        if (xfer) begin
          if (hdr_q) begin
            rem_d   = hdr_len;
            hdr_d   = 1'b0;
            pkt_end = (hdr_len == '0);
          end else begin
            // rem_q is at least 1 here, so this never wraps.
            rem_d   = rem_q - RemOne;
            pkt_end = (rem_q == RemOne);
          end
          if (pkt_end) begin
            state_d = ARB_IDLE;
            grant_d = 4'b0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = 4'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= 4'b0;
      last_q  <= 2'd3;  // requester 0 gets first priority out of reset
      rem_q   <= '0;
      hdr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      hdr_q   <= hdr_d;
    end
  end

endmodule

// File: tb/tb_fwnoc_rr_pkt_arbiter.sv
// Scoreboard bench for fwnoc_rr_pkt_arbiter. Packets are queued per
// requester; their flits are pushed as expectations at the same time. A
// negedge monitor checks every egress transfer, idle/busy outputs, the
// arbitration winner against a packet-level round-robin model, and the idle
// bubble after each packet.
module tb_fwnoc_rr_pkt_arbiter;
  import fwnoc_pkg::*;

  typedef struct {
    logic [31:0] dat;
    int          gap;   // cycles of valid=0 after this flit transfers
  } flit_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fwnoc_rr_pkt_arbiter_if #(.DAT_W(32)) bus ();

  fwnoc_rr_pkt_arbiter #(
    .DAT_W   (32),
    .LEN_LSB (16),
    .LEN_W   (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .arb   (bus)
  );

  logic [3:0]  tv = 4'b0;
  logic [31:0] td [4] = '{default: 32'h0};
  logic [3:0]  tr;
  logic        e_ready_drv = 1'b1;

  assign bus.i0_valid = tv[0];
  assign bus.i1_valid = tv[1];
  assign bus.i2_valid = tv[2];
  assign bus.i3_valid = tv[3];
  assign bus.i0_dat   = td[0];
  assign bus.i1_dat   = td[1];
  assign bus.i2_dat   = td[2];
  assign bus.i3_dat   = td[3];
  assign bus.e_ready  = e_ready_drv;
  assign tr = {bus.i3_ready, bus.i2_ready, bus.i1_ready, bus.i0_ready};

  flit_t       src_q [4][$];
  logic [31:0] exp_q [4][$];
  int          gap_cnt [4] = '{default: 0};
  logic [3:0]  fire_s = 4'b0;
  bit          erdy_pat [$];
  bit          erdy_rand = 1'b0;
  int          gnt_log [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference arbitration rule: first requester at (last+d) mod 4, d=1..4.
  function automatic int rr_model(input logic [3:0] req, input int last);
    for (int d = 1; d <= 4; d++) begin
      if (req[(last + d) % 4]) return (last + d) % 4;
    end
    return last;
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Queue one packet of 1+len flits on requester k.
  task automatic send_pkt(input int k, input int len, input int hdr_gap, input bit rnd_gap);
    flit_t       f;
    logic [31:0] w;
    for (int i = 0; i <= len; i++) begin
      if (i == 0) w = {4'(k), 4'($urandom_range(15)), 8'(len), 16'($urandom)};
      else        w = {4'(k), 28'($urandom)};
      f.dat = w;
      if (i == 0) f.gap = hdr_gap;
      else        f.gap = (rnd_gap && $urandom_range(3) == 0) ? int'($urandom_range(1, 2)) : 0;
      src_q[k].push_back(f);
      exp_q[k].push_back(w);
    end
  endtask

  // Requester and sink drivers: update just after each rising edge.
  always begin
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (!reset) begin
        src_q[k].delete();
        gap_cnt[k] = 0;
      end else if (fire_s[k] && src_q[k].size() > 0) begin
        gap_cnt[k] = src_q[k][0].gap;
        void'(src_q[k].pop_front());
      end else if (gap_cnt[k] > 0) begin
        gap_cnt[k]--;
      end
      if (src_q[k].size() > 0 && gap_cnt[k] == 0) begin
        tv[k] = 1'b1;
        td[k] = src_q[k][0].dat;
      end else begin
        tv[k] = 1'b0;
        td[k] = 32'h0;
      end
    end
    if (erdy_pat.size() > 0) e_ready_drv = erdy_pat.pop_front();
    else if (erdy_rand)      e_ready_drv = ($urandom_range(3) != 0);
    else                     e_ready_drv = 1'b1;
  end

  // Monitor / scoreboard state.
  bit         prev_busy  = 1'b0;
  logic [3:0] prev_req   = 4'b0;
  int         model_last = 3;
  int         mon_owner  = 0;
  int         mon_left   = 0;
  bit         last_pend  = 1'b0;

  always @(negedge clock) begin
    int          own;
    int          exp_own;
    logic [31:0] w;
    if (!reset) begin
      prev_busy  = 1'b0;
      prev_req   = 4'b0;
      model_last = 3;
      mon_left   = 0;
      last_pend  = 1'b0;
      fire_s     = 4'b0;
      gnt_log.delete();
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else begin
      fire_s = tv & tr;
      own    = idx_of(bus.grant);
      if (!bus.busy) begin
        check(!bus.e_valid && tr == 4'b0 && bus.grant == 4'b0, "idle_outputs",
              64'({bus.e_valid, tr, bus.grant}), 64'h0);
      end else begin
        check($onehot(bus.grant) && tr == (bus.grant & {4{e_ready_drv}}) &&
              bus.e_valid == tv[own] && (!tv[own] || bus.e_dat == td[own]), "busy_passthru",
              64'({bus.grant, tr, bus.e_valid}),
              64'({fwnoc_onehot4(2'(own)), bus.grant & {4{e_ready_drv}}, tv[own]}));
      end
      if (last_pend) begin
        check(!bus.busy, "idle_bubble", 64'(bus.busy), 64'h0);
        last_pend = 1'b0;
      end
      if (!prev_busy && (prev_req != 4'b0 || bus.busy)) begin
        exp_own = rr_model(prev_req, model_last);
        check(prev_req != 4'b0 && bus.busy && mon_left == 0 &&
              bus.grant == fwnoc_onehot4(2'(exp_own)), "arb_grant",
              64'(bus.grant), 64'(fwnoc_onehot4(2'(exp_own))));
        model_last = exp_own;
        mon_owner  = exp_own;
        gnt_log.push_back(own);
      end
      if (bus.busy && bus.e_valid && e_ready_drv) begin
        check(exp_q[own].size() > 0, "flit_expected", 64'(own), 64'(mon_owner));
        if (exp_q[own].size() > 0) begin
          w = exp_q[own].pop_front();
          check(bus.e_dat == w && own == mon_owner, "flit_data",
                64'({4'(own), bus.e_dat}), 64'({4'(mon_owner), w}));
          if (mon_left == 0) mon_left = int'(w[23:16]) + 1;
          mon_left--;
          if (mon_left == 0) last_pend = 1'b1;
        end
      end
      prev_busy = bus.busy;
      prev_req  = tv;
    end
  end

  function automatic bit pending();
    bit p = bus.busy;
    for (int k = 0; k < 4; k++) p |= (src_q[k].size() > 0) || (exp_q[k].size() > 0);
    return p;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      @(posedge clock);
      #3;
      n++;
    end
    check(n < budget, "drain_timeout", 64'(n), 64'(budget));
    repeat (2) @(posedge clock);
    #3;
  endtask

  task automatic wait_exp_size(input int k, input int sz, input int budget);
    int n = 0;
    while (exp_q[k].size() > sz && n < budget) begin
      @(posedge clock);
      #3;
      n++;
    end
    check(exp_q[k].size() == sz, "wait_flits", 64'(exp_q[k].size()), 64'(sz));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #3;
  endtask

  initial begin
    int base;
    int n;

    // Reset state.
    #12;
    check(!bus.e_valid && bus.e_dat == 32'h0 && tr == 4'b0, "reset_egress",
          64'({bus.e_valid, tr, bus.e_dat}), 64'h0);
    check(bus.grant == 4'b0 && !bus.busy, "reset_status", 64'({bus.grant, bus.busy}), 64'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #3;

    // Single packet on i2, len 3.
    send_pkt(2, 3, 0, 1'b0);
    drain(50);
    check(gnt_log.size() == 1 && gnt_log[0] == 2, "single_owner",
          64'(gnt_log.size()), 64'h1);

    // Zero-length packet from i3 with i0 waiting: i3 first (last owner was 2).
    base = gnt_log.size();
    send_pkt(3, 0, 0, 1'b0);
    send_pkt(0, 1, 0, 1'b0);
    drain(50);
    check(gnt_log.size() == base + 2 && gnt_log[base] == 3 && gnt_log[base+1] == 0,
          "zero_len_order", 64'({gnt_log[base], gnt_log[base+1]}), 64'h3_0000_0000);

    // Fairness from reset: all four backlogged with len=1 packets.
    apply_reset();
    for (int r = 0; r < 2; r++) for (int k = 0; k < 4; k++) send_pkt(k, 1, 0, 1'b0);
    drain(100);
    n = 0;
    for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] == i % 4) n++;
    check(gnt_log.size() == 8 && n == 8, "fair_rotation", 64'(n), 64'h8);

    // Backpressure on a len=2 packet from i1.
    send_pkt(1, 2, 0, 1'b0);
    n = 0;
    while (!bus.busy && n < 20) begin
      @(posedge clock);
      #3;
      n++;
    end
    check(bus.busy, "bp_grant", 64'(bus.busy), 64'h1);
    erdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    drain(50);

    // Owner stall: i0 drops valid for 4 cycles after its header, i1 waits.
    send_pkt(0, 2, 4, 1'b0);
    send_pkt(1, 1, 0, 1'b0);
    wait_exp_size(0, 2, 50);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      check(!bus.e_valid && bus.grant == 4'b0001 && !tr[1], "owner_stall",
            64'({bus.e_valid, bus.grant, tr[1]}), 64'({1'b0, 4'b0001, 1'b0}));
    end
    drain(50);

    // Maximum length field.
    send_pkt(2, 255, 0, 1'b0);
    drain(400);

    // Randomized traffic with sink backpressure and requester gaps.
    erdy_rand = 1'b1;
    for (int p = 0; p < 60; p++) begin
      send_pkt(int'($urandom_range(3)), int'($urandom_range(5)), 0, 1'b1);
      repeat ($urandom_range(6)) @(posedge clock);
      #3;
    end
    drain(5000);
    erdy_rand = 1'b0;

    // Reset in the middle of a 4-flit packet.
    send_pkt(1, 3, 0, 1'b0);
    wait_exp_size(1, 2, 50);
    reset = 1'b0;
    #1;
    check(!bus.e_valid && bus.grant == 4'b0 && !bus.busy && tr == 4'b0, "reset_midpkt",
          64'({bus.e_valid, bus.grant, bus.busy, tr}), 64'h0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #3;
    send_pkt(1, 1, 0, 1'b0);
    send_pkt(0, 1, 0, 1'b0);
    drain(50);
    check(gnt_log.size() == 2 && gnt_log[0] == 0 && gnt_log[1] == 1, "post_reset_prio",
          64'({gnt_log[0], gnt_log[1]}), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=<500000", $time);
    $fatal(1, "timeout");
  end

endmodule
